dmem_access_ctrl: RTL and testbench

Data-memory access controller for the core's memory stage; consumer of the decoder's load/store/byte control signals. Takes one decoded memory instruction at a time and runs the data-memory request/response handshake. Performs byte-lane replication for stores and byte extraction with zero-extension for loads. Holds the pipeline with `stall_o` until the access retires.

---
 rtl/dmem_access_ctrl_pkg.sv | 32 +++
 rtl/dmem_access_ctrl_if.sv | 32 +++
 rtl/dmem_access_ctrl_byte_lane.sv | 29 ++
 rtl/dmem_access_ctrl.sv | 119 +++++++++++
 tb/tb_dmem_access_ctrl.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller.
//   dmem_state_e   : controller FSM states
//   dmem_req_s     : registered memory request (valid, wen, is_byte, addr, wdata)
//   dmem_rsp_s     : memory read response (rvalid, rdata)
//   kBytesPerWord  : byte lanes per data word
package definitions;

    localparam int unsigned kBytesPerWord = 4;
    localparam int unsigned kAddrW        = 32;
    localparam int unsigned kDataW        = 8 * kBytesPerWord;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StResp,
        StDone
    } dmem_state_e;

    typedef struct packed {
        logic              valid;
        logic              wen;
        logic              is_byte;
        logic [kAddrW-1:0] addr;
        logic [kDataW-1:0] wdata;
    } dmem_req_s;

    typedef struct packed {
        logic              rvalid;
        logic [kDataW-1:0] rdata;
    } dmem_rsp_s;

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Data-memory bus between the access controller (master) and the memory (slave).
//   mem_valid_o/mem_wen_o/mem_byte_o/mem_addr_o/mem_wdata_o : request, master -> slave
//   mem_yumi_i   : slave accepts the request this cycle
//   mem_rvalid_i/mem_rdata_i : read response, slave -> master
//   mem_ryumi_o  : master consumes the response
// Signal names carry the controller's point of view.
interface dmem_access_ctrl_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();

    logic              mem_valid_o;
    logic              mem_wen_o;
    logic              mem_byte_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_yumi_i;
    logic              mem_rvalid_i;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_ryumi_o;

    modport master (
        output mem_valid_o, mem_wen_o, mem_byte_o, mem_addr_o, mem_wdata_o, mem_ryumi_o,
        input  mem_yumi_i, mem_rvalid_i, mem_rdata_i
    );

    modport slave (
        input  mem_valid_o, mem_wen_o, mem_byte_o, mem_addr_o, mem_wdata_o, mem_ryumi_o,
        output mem_yumi_i, mem_rvalid_i, mem_rdata_i
    );

endinterface

// File: rtl/dmem_access_ctrl_byte_lane.sv
// Combinational byte-lane steering.
//   is_byte_op : SB/LBU access
//   addr_lo    : byte offset within the word
//   store_data : rt value for stores
//   rdata      : word-aligned read data
//   wdata      : SB replicates the low byte into every lane, SW passes through
//   load_data  : LBU extracts the addressed lane (little-endian) zero-extended, LW passes through
module dmem_byte_lane
    import definitions::*;
(
    input  logic              is_byte_op,
    input  logic [1:0]        addr_lo,
    input  logic [kDataW-1:0] store_data,
    input  logic [kDataW-1:0] rdata,
    output logic [kDataW-1:0] wdata,
    output logic [kDataW-1:0] load_data
);

    always_comb begin
        wdata     = store_data;
        load_data = rdata;
        if (is_byte_op) begin
            wdata          = {kBytesPerWord{store_data[7:0]}};
            load_data      = '0;
            load_data[7:0] = rdata[8*addr_lo +: 8];
        end
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller for the memory stage.
// Takes one decoded load/store, runs the request/response handshake on `mem`,
// and holds the pipeline via stall_o until the access retires.
//   clk, n_reset        : clock, synchronous active-low reset
//   req_valid_i, is_load_op_i, is_store_op_i, is_byte_op_i, addr_i, store_data_i : instruction
//   stall_o             : combinational pipeline hold
//   load_data_o         : load result, valid with load_done_o
//   load_done_o, store_done_o, misaligned_o : one-cycle retire pulses
//   mem                 : memory bus (master side)
module dmem_access_ctrl
    import definitions::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic                req_valid_i,
    input  logic                is_load_op_i,
    input  logic                is_store_op_i,
    input  logic                is_byte_op_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   store_data_i,
    output logic                stall_o,
    output logic [DATA_W-1:0]   load_data_o,
    output logic                load_done_o,
    output logic                store_done_o,
    output logic                misaligned_o,
    dmem_access_ctrl_if.master  mem
);

    dmem_state_e       state_q, state_d;
    dmem_req_s         req_q;
    dmem_rsp_s         rsp;
    logic [DATA_W-1:0] load_data_q;
    logic              load_done_q, store_done_q, misaligned_q;
    logic              accept, misalign;
    logic              lane_byte;
    logic [1:0]        lane_addr;
    logic [DATA_W-1:0] lane_wdata, lane_rdata;

    // Stores are steered from the live inputs at accept; loads from the registered request.
    assign lane_byte = (state_q == StIdle) ? is_byte_op_i : req_q.is_byte;
    assign lane_addr = (state_q == StIdle) ? addr_i[1:0] : req_q.addr[1:0];

    dmem_byte_lane u_byte_lane (
        .is_byte_op (lane_byte),
        .addr_lo    (lane_addr),
        .store_data (store_data_i),
        .rdata      (rsp.rdata),
        .wdata      (lane_wdata),
        .load_data  (lane_rdata)
    );

    always_comb begin
        rsp.rvalid      = mem.mem_rvalid_i;
        rsp.rdata       = mem.mem_rdata_i;
        accept          = (state_q == StIdle) && req_valid_i && (is_load_op_i || is_store_op_i);
        misalign        = !is_byte_op_i && (addr_i[1:0] != 2'b00);
        state_d         = state_q;
        stall_o         = 1'b0;
        mem.mem_ryumi_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    stall_o = 1'b1;
                    state_d = misalign ? StDone : StReq;
                end
            end
            StReq: begin
                stall_o = 1'b1;
                // wen=0 marks a load (load wins when both op flags are set)
                if (mem.mem_yumi_i) state_d = req_q.wen ? StDone : StResp;
            end
            StResp: begin
                stall_o         = 1'b1;
                mem.mem_ryumi_o = rsp.rvalid;
                if (rsp.rvalid) state_d = StDone;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q      <= StIdle;
            req_q        <= '0;
            load_data_q  <= '0;
            load_done_q  <= 1'b0;
            store_done_q <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q.valid  <= (state_d == StReq);
            load_done_q  <= (state_q == StResp) && rsp.rvalid;
            store_done_q <= (state_q == StReq) && mem.mem_yumi_i && req_q.wen;
            misaligned_q <= accept && misalign;
            if (accept) begin
                req_q.wen     <= !is_load_op_i;
                req_q.is_byte <= is_byte_op_i;
                req_q.addr    <= addr_i;
                req_q.wdata   <= lane_wdata;
            end
            if ((state_q == StResp) && rsp.rvalid) load_data_q <= lane_rdata;
        end
    end

    assign mem.mem_valid_o = req_q.valid;
    assign mem.mem_wen_o   = req_q.wen;
    assign mem.mem_byte_o  = req_q.is_byte;
    assign mem.mem_addr_o  = req_q.addr;
    assign mem.mem_wdata_o = req_q.wdata;
    assign load_data_o     = load_data_q;
    assign load_done_o     = load_done_q;
    assign store_done_o    = store_done_q;
    assign misaligned_o    = misaligned_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed cases plus randomized accesses
// against a byte-array memory model and cycle-position timing rules.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        req_valid, is_load, is_store, is_byte;
    logic [31:0] addr, store_data;
    logic        stall, load_done, store_done, misaligned;
    logic [31:0] load_data;

    int checks = 0;
    int errors = 0;

    logic [7:0] bytes [0:1023];

    always #5 clk = ~clk;

    dmem_access_ctrl_if mem_bus ();

    dmem_access_ctrl dut (
        .clk           (clk),
        .n_reset       (n_reset),
        .req_valid_i   (req_valid),
        .is_load_op_i  (is_load),
        .is_store_op_i (is_store),
        .is_byte_op_i  (is_byte),
        .addr_i        (addr),
        .store_data_i  (store_data),
        .stall_o       (stall),
        .load_data_o   (load_data),
        .load_done_o   (load_done),
        .store_done_o  (store_done),
        .misaligned_o  (misaligned),
        .mem           (mem_bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [9:0] i;
        i = {a[9:2], 2'b00};
        return {bytes[i+3], bytes[i+2], bytes[i+1], bytes[i]};
    endfunction

    task automatic chk_quiet(input string tag);
        chk({tag, ".valid"}, {31'b0, mem_bus.mem_valid_o}, 32'd0);
        chk({tag, ".ryumi"}, {31'b0, mem_bus.mem_ryumi_o}, 32'd0);
        chk({tag, ".ldone"}, {31'b0, load_done}, 32'd0);
        chk({tag, ".sdone"}, {31'b0, store_done}, 32'd0);
        chk({tag, ".mis"}, {31'b0, misaligned}, 32'd0);
    endtask

    // Runs one instruction from a posedge; returns at the posedge ending its DONE cycle.
    task automatic access(input string tag, input logic ld, input logic st, input logic bt,
                          input logic [31:0] a, input logic [31:0] d, input int yd, input int rd);
        logic        mis, as_load, exp_valid, rv, exp_ld;
        logic [31:0] exp_w, exp_rd, r;
        int          done_c;
        if (!(ld || st)) begin
            #1;
            req_valid = 1'b1; is_load = 1'b0; is_store = 1'b0; is_byte = bt;
            addr = a; store_data = d;
            #1;
            chk({tag, ".ign.stall"}, {31'b0, stall}, 32'd0);
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            #1;
            chk({tag, ".ign"}, {31'b0, stall}, 32'd0);
            chk_quiet({tag, ".ign"});
            @(posedge clk);
            return;
        end
        mis     = !bt && (a[1:0] != 2'b00);
        as_load = ld;
        exp_w   = bt ? {4{d[7:0]}} : d;
        exp_rd  = bt ? {24'b0, bytes[a[9:0]]} : word_at(a);
        if (mis) done_c = 1;
        else if (!as_load) done_c = 2 + yd;
        else done_c = 3 + yd + rd;
        for (int c = 0; c <= done_c; c++) begin
            #1;
            req_valid = 1'b1; is_load = ld; is_store = st; is_byte = bt;
            addr = a; store_data = d;
            mem_bus.mem_yumi_i = !mis && (c == 1 + yd);
            rv = as_load && !mis && (c == 2 + yd + rd);
            mem_bus.mem_rvalid_i = rv;
            r = $urandom;
            mem_bus.mem_rdata_i = rv ? word_at(a) : r;
            #1;
            exp_valid = !mis && (c >= 1) && (c <= 1 + yd);
            exp_ld    = (c == done_c) && as_load && !mis;
            chk({tag, ".stall"}, {31'b0, stall}, {31'b0, c < done_c});
            chk({tag, ".valid"}, {31'b0, mem_bus.mem_valid_o}, {31'b0, exp_valid});
            if (exp_valid) begin
                chk({tag, ".wen"}, {31'b0, mem_bus.mem_wen_o}, {31'b0, !as_load});
                chk({tag, ".byte"}, {31'b0, mem_bus.mem_byte_o}, {31'b0, bt});
                chk({tag, ".addr"}, mem_bus.mem_addr_o, a);
                if (!as_load) chk({tag, ".wdata"}, mem_bus.mem_wdata_o, exp_w);
            end
            chk({tag, ".ryumi"}, {31'b0, mem_bus.mem_ryumi_o}, {31'b0, rv});
            chk({tag, ".ldone"}, {31'b0, load_done}, {31'b0, exp_ld});
            chk({tag, ".sdone"}, {31'b0, store_done},
                {31'b0, (c == done_c) && !as_load && !mis});
            chk({tag, ".mis"}, {31'b0, misaligned}, {31'b0, (c == done_c) && mis});
            if (exp_ld) chk({tag, ".ldata"}, load_data, exp_rd);
            // Memory model performs the write when the store is accepted.
            if (mem_bus.mem_yumi_i && !as_load) begin
                if (bt) bytes[a[9:0]] = d[7:0];
                else for (int k = 0; k < 4; k++) bytes[{a[9:2], 2'b00} + 10'(k)] = d[8*k +: 8];
            end
            @(posedge clk);
        end
        #1;
        req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
        mem_bus.mem_yumi_i = 1'b0; mem_bus.mem_rvalid_i = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        logic [31:0] r, ra, rd32;
        logic [31:0] a;
        logic        bt;
        for (int i = 0; i < 1024; i++) bytes[i] = 8'($urandom);
        n_reset = 1'b0;
        req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; is_byte = 1'b0;
        addr = '0; store_data = '0;
        mem_bus.mem_yumi_i = 1'b0; mem_bus.mem_rvalid_i = 1'b0; mem_bus.mem_rdata_i = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.stall", {31'b0, stall}, 32'd0);
        chk("rst.wen", {31'b0, mem_bus.mem_wen_o}, 32'd0);
        chk("rst.byte", {31'b0, mem_bus.mem_byte_o}, 32'd0);
        chk("rst.addr", mem_bus.mem_addr_o, 32'd0);
        chk("rst.wdata", mem_bus.mem_wdata_o, 32'd0);
        chk("rst.ldata", load_data, 32'd0);
        chk_quiet("rst");
        n_reset = 1'b1;
        @(posedge clk);

        // Directed cases
        access("sw", 1'b0, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 0, 0);
        access("sb", 1'b0, 1'b1, 1'b1, 32'h103, 32'h000000A5, 0, 0);
        bytes[10'h200] = 8'h44; bytes[10'h201] = 8'h33;
        bytes[10'h202] = 8'h22; bytes[10'h203] = 8'h11;
        access("lbu", 1'b1, 1'b0, 1'b1, 32'h202, 32'h0, 0, 0);
        access("lw", 1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 0, 0);
        access("lw_wait", 1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 3, 2);
        access("lw_mis", 1'b1, 1'b0, 1'b0, 32'h101, 32'h0, 0, 0);
        access("both", 1'b1, 1'b1, 1'b0, 32'h200, 32'h55, 1, 1);
        access("none", 1'b0, 1'b0, 1'b0, 32'h200, 32'h55, 0, 0);

        // Stray response while idle
        #1;
        mem_bus.mem_rvalid_i = 1'b1;
        #1;
        chk("stray.stall", {31'b0, stall}, 32'd0);
        chk_quiet("stray");
        @(posedge clk);
        #1;
        mem_bus.mem_rvalid_i = 1'b0;
        @(posedge clk);

        // Reset while waiting in RESP: cycle 0 accept, 1 yumi, 2 RESP with reset low
        #1;
        req_valid = 1'b1; is_load = 1'b1; is_byte = 1'b0; addr = 32'h204;
        @(posedge clk);
        #1;
        mem_bus.mem_yumi_i = 1'b1;
        @(posedge clk);
        #1;
        mem_bus.mem_yumi_i = 1'b0;
        n_reset = 1'b0;
        @(posedge clk);
        #1;
        n_reset = 1'b1;
        req_valid = 1'b0; is_load = 1'b0;
        #1;
        chk("rresp.stall", {31'b0, stall}, 32'd0);
        chk("rresp.addr", mem_bus.mem_addr_o, 32'd0);
        chk("rresp.wen", {31'b0, mem_bus.mem_wen_o}, 32'd0);
        chk("rresp.ldata", load_data, 32'd0);
        chk_quiet("rresp");
        @(posedge clk);
        #1;
        mem_bus.mem_rvalid_i = 1'b1;
        mem_bus.mem_rdata_i = 32'hCAFEF00D;
        #1;
        chk("late.ryumi", {31'b0, mem_bus.mem_ryumi_o}, 32'd0);
        chk("late.stall", {31'b0, stall}, 32'd0);
        @(posedge clk);
        #1;
        mem_bus.mem_rvalid_i = 1'b0;
        #1;
        chk_quiet("late");
        @(posedge clk);
        access("after_rst", 1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 1, 0);

        // Randomized accesses
        for (int n = 0; n < 40; n++) begin
            r    = $urandom;
            ra   = $urandom;
            rd32 = $urandom;
            bt   = r[2];
            a    = {22'b0, ra[9:0]};
            if (!bt && (ra[31:29] != 3'b000)) a[1:0] = 2'b00;
            access($sformatf("rnd%0d", n), r[0], r[1], bt, a, rd32,
                   int'(r[5:4]), int'(r[7:6]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
